// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encoding and default timing for the display sequencer
package disp_pkg;

  localparam int DEF_H_BYTES    = 120;
  localparam int DEF_V_LINES    = 240;
  localparam int DEF_LP_WIDTH   = 4;
  localparam int DEF_BLANK_CLKS = 8;
  localparam int TMR_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_ACTIVE,
    ST_HOLD,
    ST_LATCH,
    ST_BLANK
  } disp_state_t;

  // 76800 px mod 9 = 3, so the RGB start phase advances by one third per frame.
  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/disp_pulse_timer.sv
// rtl/disp_pulse_timer.sv - loadable down-counter timing the latch and blank intervals
module disp_pulse_timer
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  // A load of N keeps the caller in its state for N clocks; done marks the last one.
  assign done = (cnt == TMR_W'(1));

endmodule

// File: rtl/disp_seq.sv
// rtl/disp_seq.sv - byte-paced line/frame sequencer for a 3-bit RGB panel converter
module disp_seq
  import disp_pkg::*;
#(
  parameter int H_BYTES    = DEF_H_BYTES,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int LP_WIDTH   = DEF_LP_WIDTH,
  parameter int BLANK_CLKS = DEF_BLANK_CLKS
) (
  input  logic       IN_CLK,
  input  logic       IN_RST_N,
  input  logic       IN_EN,
  input  logic       IN_VSYNC,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       IN_ERR_CLR,
  output logic       OUT_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_CONV_CP,
  output logic       OUT_CONV_LINE,
  output logic       OUT_LP,
  output logic       OUT_FLM,
  output logic       OUT_M,
  output logic [1:0] OUT_PHASE,
  output logic       OUT_BUSY,
  output logic       OUT_ERR
);

  localparam int BYTE_W = $clog2(H_BYTES + 1);
  localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  disp_state_t       state;
  logic [BYTE_W-1:0] byte_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              tmr_load;
  logic              tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              resync;
  logic              line_full;
  logic              last_line;
  logic              blank_end;

  assign resync    = IN_VSYNC && (state inside {ST_ACTIVE, ST_HOLD, ST_LATCH, ST_BLANK});
  assign line_full = (byte_cnt == BYTE_W'(H_BYTES));
  assign last_line = (line_cnt == LINE_W'(V_LINES - 1));
  // With no blank interval the end of the latch pulse doubles as the end of blank.
  assign blank_end = tmr_done &&
                     ((state == ST_BLANK) || ((state == ST_LATCH) && (BLANK_CLKS == 0)));
  assign tmr_load  = ((state == ST_HOLD) && line_full) || ((state == ST_LATCH) && tmr_done);
  assign tmr_val   = (state == ST_HOLD) ? TMR_W'(LP_WIDTH) : TMR_W'(BLANK_CLKS);

  disp_pulse_timer u_timer (
    .clk      (IN_CLK),
    .resetn   (IN_RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge IN_CLK) begin
    if (!IN_RST_N) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      line_cnt      <= '0;
      OUT_DATA      <= 8'h00;
      OUT_READY     <= 1'b0;
      OUT_CONV_CP   <= 1'b0;
      OUT_CONV_LINE <= 1'b1;
      OUT_LP        <= 1'b0;
      OUT_FLM       <= 1'b0;
      OUT_M         <= 1'b0;
      OUT_PHASE     <= 2'd0;
      OUT_BUSY      <= 1'b0;
      OUT_ERR       <= 1'b0;
    end else begin
      OUT_READY     <= 1'b0;
      OUT_CONV_CP   <= 1'b0;
      OUT_CONV_LINE <= 1'b0;
      OUT_LP        <= 1'b0;
      OUT_FLM       <= 1'b0;

      if (resync) begin
        OUT_ERR <= 1'b1;
      end else if (IN_ERR_CLR) begin
        OUT_ERR <= 1'b0;
      end

      if (resync) begin
        // Restart the frame and flush the converter; polarity and phase are kept.
        state         <= ST_ACTIVE;
        byte_cnt      <= '0;
        line_cnt      <= '0;
        OUT_READY     <= 1'b1;
        OUT_CONV_LINE <= 1'b1;
      end else if (blank_end) begin
        if (!last_line) begin
          line_cnt  <= line_cnt + LINE_W'(1);
          state     <= ST_ACTIVE;
          OUT_READY <= 1'b1;
        end else begin
          line_cnt  <= '0;
          OUT_M     <= ~OUT_M;
          OUT_PHASE <= next_phase(OUT_PHASE);
          OUT_BUSY  <= 1'b0;
          state     <= IN_EN ? ST_WAIT_VS : ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (IN_EN) state <= ST_WAIT_VS;
          end
          ST_WAIT_VS: begin
            if (!IN_EN) begin
              state <= ST_IDLE;
            end else if (IN_VSYNC) begin
              state     <= ST_ACTIVE;
              byte_cnt  <= '0;
              line_cnt  <= '0;
              OUT_READY <= 1'b1;
              OUT_BUSY  <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (IN_VALID) begin
              OUT_DATA    <= IN_DATA;
              OUT_CONV_CP <= 1'b1;
              byte_cnt    <= byte_cnt + BYTE_W'(1);
              state       <= ST_HOLD;
            end else begin
              OUT_READY <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (line_full) begin
              byte_cnt      <= '0;
              state         <= ST_LATCH;
              OUT_LP        <= 1'b1;
              OUT_CONV_LINE <= 1'b1;
              OUT_FLM       <= (line_cnt == '0);
            end else begin
              state     <= ST_ACTIVE;
              OUT_READY <= 1'b1;
            end
          end
          ST_LATCH: begin
            if (tmr_done) begin
              state <= ST_BLANK;
            end else begin
              OUT_LP        <= 1'b1;
              OUT_CONV_LINE <= 1'b1;
              OUT_FLM       <= (line_cnt == '0);
            end
          end
          ST_BLANK: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_seq.sv
// tb/tb_disp_seq.sv - scoreboard bench for disp_seq on a 3-byte, 2-line geometry
`timescale 1ns/1ps
module tb_disp_seq;

  localparam int H   = 3;
  localparam int V   = 2;
  localparam int LPW = 2;
  localparam int BLK = 1;

  typedef enum int {EV_BYTE, EV_LP, EV_FLUSH, EV_FRAME, EV_ERR, EV_ERRCLR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       off;
  } ev_t;

  ev_t exp_q[$];

  logic       IN_CLK = 1'b0;
  logic       IN_RST_N = 1'b0;
  logic       IN_EN = 1'b0;
  logic       IN_VSYNC = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_ERR_CLR = 1'b0;
  logic       OUT_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_CONV_CP;
  logic       OUT_CONV_LINE;
  logic       OUT_LP;
  logic       OUT_FLM;
  logic       OUT_M;
  logic [1:0] OUT_PHASE;
  logic       OUT_BUSY;
  logic       OUT_ERR;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int vs_cyc = 0;

  disp_seq #(
    .H_BYTES    (H),
    .V_LINES    (V),
    .LP_WIDTH   (LPW),
    .BLANK_CLKS (BLK)
  ) dut (
    .IN_CLK        (IN_CLK),
    .IN_RST_N      (IN_RST_N),
    .IN_EN         (IN_EN),
    .IN_VSYNC      (IN_VSYNC),
    .IN_VALID      (IN_VALID),
    .IN_DATA       (IN_DATA),
    .IN_ERR_CLR    (IN_ERR_CLR),
    .OUT_READY     (OUT_READY),
    .OUT_DATA      (OUT_DATA),
    .OUT_CONV_CP   (OUT_CONV_CP),
    .OUT_CONV_LINE (OUT_CONV_LINE),
    .OUT_LP        (OUT_LP),
    .OUT_FLM       (OUT_FLM),
    .OUT_M         (OUT_M),
    .OUT_PHASE     (OUT_PHASE),
    .OUT_BUSY      (OUT_BUSY),
    .OUT_ERR       (OUT_ERR)
  );

  always #5 IN_CLK = ~IN_CLK;
  always @(posedge IN_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int v, input int o);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.off  = o;
    exp_q.push_back(e);
  endtask

  task automatic emit(input ev_kind_t k, input int v, input int o);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s val %0d at +%0d, expected none", k.name(), v, o);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.val != v || (e.off >= 0 && e.off != o)) begin
      n_fail++;
      $display("FAIL event: got %s val %0d at +%0d, expected %s val %0d at +%0d",
               k.name(), v, o, e.kind.name(), e.val, e.off);
    end
  endtask

  // Monitor: turns output activity into events and compares against the queue.
  bit cp_p, busy_p, err_p, in_lp;
  int lp_w, lp_f, lp_c, lp_s, fl_w;

  initial begin
    forever begin
      @(posedge IN_CLK);
      #2;
      if (!IN_RST_N) begin
        cp_p = 0; busy_p = 0; err_p = 0; in_lp = 0; fl_w = 0;
      end else begin
        if (OUT_ERR && !err_p) emit(EV_ERR, 1, cyc - vs_cyc);
        if (!OUT_ERR && err_p) emit(EV_ERRCLR, 0, cyc - vs_cyc);
        err_p = OUT_ERR;
        if (OUT_CONV_LINE && !OUT_LP) begin
          fl_w++;
        end else if (fl_w > 0) begin
          emit(EV_FLUSH, fl_w, cyc - vs_cyc);
          fl_w = 0;
        end
        if (OUT_LP) begin
          if (!in_lp) begin
            in_lp = 1; lp_w = 0; lp_f = 0; lp_c = 0; lp_s = cyc;
          end
          lp_w++;
          lp_f += int'(OUT_FLM);
          lp_c += int'(OUT_CONV_LINE);
        end else if (in_lp) begin
          in_lp = 0;
          emit(EV_LP, lp_w * 100 + lp_f * 10 + lp_c, lp_s - vs_cyc);
        end
        if (OUT_CONV_CP && !cp_p) emit(EV_BYTE, int'(OUT_DATA), cyc - vs_cyc);
        cp_p = OUT_CONV_CP;
        if (!OUT_BUSY && busy_p) emit(EV_FRAME, int'(OUT_M) * 10 + int'(OUT_PHASE), cyc - vs_cyc);
        busy_p = OUT_BUSY;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      ok = OUT_READY;
      @(negedge IN_CLK);
    end
    check("send_byte_accepted", int'(ok), 1);
  endtask

  task automatic send_exp(input logic [7:0] b, input int off);
    push(EV_BYTE, int'(b), off);
    send_byte(b);
  endtask

  task automatic start_frame();
    IN_VSYNC = 1'b1;
    IN_VALID = 1'b0;
    vs_cyc   = cyc + 1;
    @(negedge IN_CLK);
    IN_VSYNC = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (OUT_BUSY && k < 200) begin
      @(negedge IN_CLK);
      k++;
    end
    check("frame_end_busy", int'(OUT_BUSY), 0);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!OUT_READY && k < 100) begin
      @(negedge IN_CLK);
      k++;
    end
    check("wait_ready", int'(OUT_READY), 1);
  endtask

  // Full frame; timed frames also check cycle offsets from the VSYNC edge.
  task automatic run_frame(input int base, input bit timed, input int m_ph);
    logic [7:0] b;
    start_frame();
    for (int l = 0; l < V; l++) begin
      for (int i = 0; i < H; i++) begin
        b = 8'(base + 17 * (l * H + i + 1));
        send_exp(b, timed ? 1 + 2 * i + 9 * l : -1);
      end
      push(EV_LP, (l == 0) ? 222 : 202, timed ? 6 + 9 * l : -1);
    end
    push(EV_FRAME, m_ph, timed ? 18 : -1);
    IN_VALID = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge IN_CLK);
    check("rst_ready", int'(OUT_READY), 0);
    check("rst_cp", int'(OUT_CONV_CP), 0);
    check("rst_conv_line", int'(OUT_CONV_LINE), 1);
    check("rst_lp", int'(OUT_LP), 0);
    check("rst_flm", int'(OUT_FLM), 0);
    check("rst_m", int'(OUT_M), 0);
    check("rst_phase", int'(OUT_PHASE), 0);
    check("rst_busy", int'(OUT_BUSY), 0);
    check("rst_err", int'(OUT_ERR), 0);
    check("rst_data", int'(OUT_DATA), 0);

    IN_RST_N = 1'b1;
    IN_EN    = 1'b1;
    repeat (2) @(negedge IN_CLK);
    check("wait_vs_conv_line", int'(OUT_CONV_LINE), 0);

    run_frame(0, 1'b1, 11);
    run_frame(5, 1'b0, 2);
    run_frame(10, 1'b0, 10);

    // Source stalls for 10 clocks after the first byte.
    start_frame();
    send_exp(8'hA1, -1);
    IN_VALID = 1'b0;
    @(negedge IN_CLK);
    for (int i = 0; i < 10; i++) begin
      check("stall_rdy_cp_lp_data", int'({OUT_READY, OUT_CONV_CP, OUT_LP, OUT_DATA}), 'h4A1);
      @(negedge IN_CLK);
    end
    send_exp(8'hA2, -1);
    send_exp(8'hA3, -1);
    push(EV_LP, 222, -1);
    send_exp(8'hA4, -1);
    send_exp(8'hA5, -1);
    send_exp(8'hA6, -1);
    push(EV_LP, 202, -1);
    push(EV_FRAME, 1, -1);
    IN_VALID = 1'b0;
    wait_idle();

    // VSYNC collides with the second byte's handshake.
    start_frame();
    send_exp(8'hB1, -1);
    IN_VALID = 1'b0;
    wait_ready();
    IN_DATA  = 8'hB2;
    IN_VALID = 1'b1;
    IN_VSYNC = 1'b1;
    push(EV_ERR, 1, -1);
    push(EV_FLUSH, 1, -1);
    @(negedge IN_CLK);
    IN_VSYNC = 1'b0;
    IN_VALID = 1'b0;
    check("resync_err", int'(OUT_ERR), 1);
    check("resync_conv_line", int'(OUT_CONV_LINE), 1);
    check("resync_cp", int'(OUT_CONV_CP), 0);
    check("resync_ready", int'(OUT_READY), 1);
    check("resync_data_held", int'(OUT_DATA), 'hB1);
    send_exp(8'hC1, -1);
    send_exp(8'hC2, -1);
    send_exp(8'hC3, -1);
    push(EV_LP, 222, -1);
    send_exp(8'hC4, -1);
    send_exp(8'hC5, -1);
    send_exp(8'hC6, -1);
    push(EV_LP, 202, -1);
    push(EV_FRAME, 12, -1);
    IN_VALID = 1'b0;
    wait_idle();
    check("err_sticky", int'(OUT_ERR), 1);
    push(EV_ERRCLR, 0, -1);
    IN_ERR_CLR = 1'b1;
    @(negedge IN_CLK);
    IN_ERR_CLR = 1'b0;
    check("err_cleared", int'(OUT_ERR), 0);

    // Reset asserted while the line latch pulse is high.
    start_frame();
    send_exp(8'hD1, -1);
    send_exp(8'hD2, -1);
    send_exp(8'hD3, -1);
    IN_VALID = 1'b0;
    for (int k = 0; k < 20 && !OUT_LP; k++) @(negedge IN_CLK);
    check("latch_reached", int'(OUT_LP), 1);
    IN_RST_N = 1'b0;
    @(negedge IN_CLK);
    check("latch_rst_lp", int'(OUT_LP), 0);
    check("latch_rst_conv_line", int'(OUT_CONV_LINE), 1);
    check("latch_rst_phase", int'(OUT_PHASE), 0);
    check("latch_rst_m", int'(OUT_M), 0);
    check("latch_rst_busy", int'(OUT_BUSY), 0);
    check("latch_rst_ready", int'(OUT_READY), 0);
    IN_RST_N = 1'b1;
    repeat (4) @(negedge IN_CLK);
    check("latch_rst_no_lp", int'(OUT_LP), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/disp_seq.md
DISP_SEQ -- requirements
Module: disp_seq

Interface
REQ-001 The parameter list SHALL be:
- H_BYTES, default 120: input bytes per line (320 px x 3 bits / 8).
- V_LINES, default 240: lines per frame.
- LP_WIDTH, default 4: line-latch pulse width in clocks, range 1..15.
- BLANK_CLKS, default 8: idle clocks after each latch pulse, range 0..255.

REQ-002 The port list SHALL be (name, direction, width, meaning):
- IN_CLK, in, 1: system clock; every register changes only on its rising edge.
- IN_RST_N, in, 1: reset, synchronous, active-low.
- IN_EN, in, 1: frame enable.
- IN_VSYNC, in, 1: source frame-start strobe.
- IN_VALID, in, 1: source byte valid.
- IN_DATA, in, 8: source byte, RGB-packed, bit 7 = first R.
- IN_ERR_CLR, in, 1: clears OUT_ERR.
- OUT_READY, out, 1: byte accepted when IN_VALID && OUT_READY.
- OUT_DATA, out, 8: registered byte presented to the converter.
- OUT_CONV_CP, out, 1: converter byte clock; the converter samples OUT_DATA on its falling edge.
- OUT_CONV_LINE, out, 1: converter line clear.
- OUT_LP, out, 1: panel line latch.
- OUT_FLM, out, 1: panel first-line marker.
- OUT_M, out, 1: panel AC-drive polarity.
- OUT_PHASE, out, 2: frame colour phase, values 0..2.
- OUT_BUSY, out, 1: high when state is not IDLE or WAIT_VS.
- OUT_ERR, out, 1: sticky resync error flag.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_VS, ACTIVE, HOLD, LATCH, BLANK.

REQ-004 IDLE SHALL go to WAIT_VS when IN_EN=1; WAIT_VS SHALL go to IDLE when IN_EN=0, else to ACTIVE on IN_VSYNC=1 with line=0, byte=0.

REQ-005 In ACTIVE, OUT_READY SHALL be 1. On handshake the block SHALL load OUT_DATA<=IN_DATA, set OUT_CONV_CP=1 for exactly one clock (the following cycle), increment byte, and enter HOLD.

REQ-006 In HOLD, OUT_READY=0 and OUT_CONV_CP=1. HOLD SHALL last one clock and then:
- return to ACTIVE if byte<H_BYTES;
- go to LATCH with byte<=0 if byte==H_BYTES.
Peak rate is therefore one byte per 2 clocks, and OUT_CONV_CP is low at least 1 clock between pulses.

REQ-007 ACTIVE with IN_VALID=0 SHALL wait indefinitely with all outputs held; there is no underrun timeout.

REQ-008 In LATCH:
- OUT_LP=1 and OUT_CONV_LINE=1 for exactly LP_WIDTH clocks;
- OUT_FLM=1 during the same clocks only when line==0;
- OUT_DATA SHALL be held.

REQ-009 After LATCH the block SHALL stay in BLANK for BLANK_CLKS clocks; BLANK_CLKS=0 SHALL pass through BLANK in zero clocks, going directly from LATCH to the next state.

REQ-010 At the end of BLANK, if line<V_LINES-1 the block SHALL set line<=line+1 and enter ACTIVE.

REQ-011 At end of frame (end of BLANK with line==V_LINES-1) the block SHALL:
- toggle OUT_M;
- set OUT_PHASE<=(OUT_PHASE+1) mod 3, because 76800 px mod 9 = 3 shifts the RGB start phase by one third per frame;
- enter WAIT_VS, or IDLE if IN_EN=0.

REQ-012 IN_VSYNC=1 in ACTIVE, HOLD, LATCH or BLANK SHALL:
- set OUT_ERR=1;
- force ACTIVE with line=0, byte=0;
- drive OUT_CONV_LINE=1 for that one clock to flush converter state;
- leave OUT_M and OUT_PHASE unchanged.

REQ-013 A handshake and IN_VSYNC in the same ACTIVE cycle SHALL give priority to IN_VSYNC; the byte is discarded and OUT_CONV_CP stays 0.

REQ-014 IN_ERR_CLR=1 SHALL clear OUT_ERR next clock; when IN_ERR_CLR and a set condition occur in the same cycle, the set SHALL win.

REQ-015 IN_EN=0 outside IDLE/WAIT_VS SHALL NOT abort the frame; it is evaluated only at end of frame.

REQ-016 Counter widths SHALL be $clog2 of their maxima; byte and line counters SHALL never exceed H_BYTES and V_LINES-1 respectively.

Reset
REQ-017 IN_RST_N=0 at a rising edge SHALL, regardless of state:
- set state IDLE and all counters to 0;
- set OUT_DATA=8'h00;
- set OUT_READY, OUT_CONV_CP, OUT_LP, OUT_FLM, OUT_M, OUT_BUSY, OUT_ERR to 0;
- set OUT_PHASE=0;
- set OUT_CONV_LINE=1, held while reset is asserted so the converter is cleared.

REQ-018 Reset mid-line SHALL abandon any partial line; no OUT_LP pulse is emitted.

Structure
REQ-019 The state encoding and the default timing constants (120, 240, 4, 8) SHALL live in a shared package disp_pkg.

REQ-020 LATCH/BLANK timing SHALL use one sub-module, disp_pulse_timer: a loadable down-counter with a done strobe, instantiated once.

Verification (bench parameters H_BYTES=3, V_LINES=2, LP_WIDTH=2, BLANK_CLKS=1)
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then IN_EN=1 and a single-cycle IN_VSYNC, then IN_VALID held 1 with bytes 11,22,33 -> OUT_CONV_CP pulses at cycles 1,3,5 after VSYNC, with OUT_DATA=11,22,33 during each pulse; then OUT_LP and OUT_FLM high 2 clocks, BLANK 1 clock, line 1 starts.
- Line 1 completes -> OUT_LP high 2 clocks with OUT_FLM=0; then OUT_M 0->1, OUT_PHASE 0->1, OUT_BUSY falls.
- Three full frames -> OUT_PHASE sequence 1,2,0; OUT_M sequence 1,0,1.
- IN_VALID low 10 clocks after byte 1 -> OUT_READY stays 1, no OUT_CONV_CP, no OUT_LP, OUT_DATA held.
- IN_VSYNC during the second byte's handshake -> OUT_ERR=1, OUT_CONV_LINE=1 for 1 clock, byte counter restarts so 3 further bytes are needed for OUT_LP; IN_ERR_CLR then clears OUT_ERR.
- IN_RST_N low during LATCH -> next clock OUT_LP=0, OUT_CONV_LINE=1, OUT_PHASE=0, state IDLE.
